// File: rtl/stepper_step_scheduler_if.sv
// Command handshake carrying relative move requests into one stepper scheduler.
interface stepper_step_scheduler_if #(
    parameter int COUNT_W  = 16,
    parameter int PERIOD_W = 16
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic signed [COUNT_W-1:0]  cmd_steps;
    logic        [PERIOD_W-1:0] cmd_period;
    logic        [3:0]          cmd_microstep;

    modport master (
        output cmd_valid, cmd_steps, cmd_period, cmd_microstep,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_period, cmd_microstep,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_step_scheduler.sv
// Step/direction sequencer for one A3988 channel with absolute quarter-step position tracking.
// Define STEPPER_SCHED_MORPH_EN to enable microstep morphing (fill steps before a coarser mode).
module stepper_step_scheduler #(
    parameter int COUNT_W    = 16,
    parameter int PERIOD_W   = 16,
    parameter int POS_W      = 24,
    parameter int STEP_HIGH  = 4,
    parameter int DIR_SETUP  = 4,
    parameter int MIN_PERIOD = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    stepper_step_scheduler_if.slave  cmd,
    input  logic                     i_abort,
    input  logic [1:0]               i_morph_transition,
    output logic                     o_step,
    output logic                     o_dir,
    output logic [3:0]               o_microstep,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_aborted,
    output logic                     o_cmd_error,
    output logic signed [POS_W-1:0]  o_position
);

`ifdef STEPPER_SCHED_MORPH_EN
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_SETUP, S_STEP_HI, S_STEP_LO} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP_HI, S_STEP_LO} state_t;
`endif

    state_t                   r_state, w_nextState;
    logic                     r_dir;
    logic [3:0]               r_microstep;
    logic [COUNT_W-1:0]       r_remaining;
    logic [PERIOD_W-1:0]      r_period;
    logic [PERIOD_W-1:0]      r_timer, w_timerNext;
    logic signed [POS_W-1:0]  r_position;
    logic                     r_abortPend, r_done, r_aborted, r_cmdError;

    logic                     w_accept, w_msValid, w_newDir, w_needSetup;
    logic                     w_timerZero, w_abortPend;
    logic [COUNT_W-1:0]       w_absSteps;
    logic [PERIOD_W-1:0]      w_period;
    logic signed [POS_W-1:0]  w_delta;
    logic                     w_loadCmd, w_enterHi, w_fillStep;
    logic                     w_finishDone, w_finishAbort, w_error;

`ifdef STEPPER_SCHED_MORPH_EN
    logic                     r_fill;
    logic [1:0]               r_fillCnt;
    logic [3:0]               r_targetMs;
    logic                     w_needFill, w_leaveFill;

    // Coarsening to full needs the full/half boundary; to half either boundary will do.
    function automatic logic flagOk(input logic [3:0] ms, input logic [1:0] flags);
        return (ms == 4'd1) ? flags[0] : (flags[0] | flags[1]);
    endfunction

    assign w_needFill = (cmd.cmd_microstep < r_microstep) &&
                        !flagOk(cmd.cmd_microstep, i_morph_transition);
`else
    logic w_unused_morph;
    assign w_unused_morph = ^i_morph_transition;
`endif

    assign w_accept    = cmd.cmd_valid && (r_state == S_IDLE);
    assign w_msValid   = (cmd.cmd_microstep == 4'd1) || (cmd.cmd_microstep == 4'd2) ||
                         (cmd.cmd_microstep == 4'd4);
    assign w_newDir    = !cmd.cmd_steps[COUNT_W-1];
    assign w_absSteps  = cmd.cmd_steps[COUNT_W-1] ? (~cmd.cmd_steps + 1'b1) : cmd.cmd_steps;
    assign w_period    = (cmd.cmd_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                                  : cmd.cmd_period;
    assign w_needSetup = (w_newDir != r_dir) || (cmd.cmd_microstep != r_microstep);
    assign w_timerZero = (r_timer == '0);
    assign w_abortPend = r_abortPend || i_abort;

    always_comb begin
        w_delta = POS_W'(1);
        case (r_microstep)
            4'd1:    w_delta = POS_W'(4);
            4'd2:    w_delta = POS_W'(2);
            default: w_delta = POS_W'(1);
        endcase
        if (!r_dir) w_delta = -w_delta;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState   = r_state;
        w_timerNext   = r_timer;
        w_loadCmd     = 1'b0;
        w_enterHi     = 1'b0;
        w_fillStep    = 1'b0;
        w_finishDone  = 1'b0;
        w_finishAbort = 1'b0;
        w_error       = 1'b0;
`ifdef STEPPER_SCHED_MORPH_EN
        w_leaveFill   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_msValid) begin
                        w_error = 1'b1;
                    end else if (cmd.cmd_steps == '0) begin
                        w_finishDone = 1'b1;
                    end else begin
                        w_loadCmd = 1'b1;
                        if (w_needSetup) begin
                            w_nextState = S_SETUP;
                            w_timerNext = PERIOD_W'(DIR_SETUP - 1);
                        end else begin
                            w_nextState = S_STEP_HI;
                            w_enterHi   = 1'b1;
                            w_timerNext = PERIOD_W'(STEP_HIGH - 1);
                        end
`ifdef STEPPER_SCHED_MORPH_EN
                        if (w_needFill) begin
                            w_fillStep = 1'b1;
                            if (w_newDir != r_dir) begin
                                w_nextState = S_FILL;
                                w_enterHi   = 1'b0;
                                w_timerNext = PERIOD_W'(DIR_SETUP - 1);
                            end else begin
                                w_nextState = S_STEP_HI;
                                w_enterHi   = 1'b1;
                                w_timerNext = PERIOD_W'(STEP_HIGH - 1);
                            end
                        end
`endif
                    end
                end
            end
`ifdef STEPPER_SCHED_MORPH_EN
            S_FILL: begin
                if (i_abort) begin
                    w_nextState   = S_IDLE;
                    w_finishAbort = 1'b1;
                end else if (w_timerZero) begin
                    w_nextState = S_STEP_HI;
                    w_enterHi   = 1'b1;
                    w_fillStep  = 1'b1;
                    w_timerNext = PERIOD_W'(STEP_HIGH - 1);
                end else begin
                    w_timerNext = r_timer - 1'b1;
                end
            end
`endif
            S_SETUP: begin
                if (i_abort) begin
                    w_nextState   = S_IDLE;
                    w_finishAbort = 1'b1;
                end else if (w_timerZero) begin
                    w_nextState = S_STEP_HI;
                    w_enterHi   = 1'b1;
                    w_timerNext = PERIOD_W'(STEP_HIGH - 1);
                end else begin
                    w_timerNext = r_timer - 1'b1;
                end
            end
            S_STEP_HI: begin
                if (w_timerZero) begin
                    w_nextState = S_STEP_LO;
                    w_timerNext = r_period - PERIOD_W'(STEP_HIGH) - 1'b1;
                end else begin
                    w_timerNext = r_timer - 1'b1;
                end
            end
            S_STEP_LO: begin
                if (!w_timerZero) begin
                    w_timerNext = r_timer - 1'b1;
                end else
`ifdef STEPPER_SCHED_MORPH_EN
                if (r_fill) begin
                    if (w_abortPend) begin
                        w_nextState   = S_IDLE;
                        w_finishAbort = 1'b1;
                    end else if (flagOk(r_targetMs, i_morph_transition)) begin
                        w_leaveFill = 1'b1;
                        w_nextState = S_SETUP;
                        w_timerNext = PERIOD_W'(DIR_SETUP - 1);
                    end else if (r_fillCnt == 2'd3) begin
                        w_nextState = S_IDLE;
                        w_error     = 1'b1;
                    end else begin
                        w_nextState = S_STEP_HI;
                        w_enterHi   = 1'b1;
                        w_fillStep  = 1'b1;
                        w_timerNext = PERIOD_W'(STEP_HIGH - 1);
                    end
                end else
`endif
                begin
                    // Reaching zero wins over a pending abort so the move reports done.
                    if (r_remaining == '0) begin
                        w_nextState  = S_IDLE;
                        w_finishDone = 1'b1;
                    end else if (w_abortPend) begin
                        w_nextState   = S_IDLE;
                        w_finishAbort = 1'b1;
                    end else begin
                        w_nextState = S_STEP_HI;
                        w_enterHi   = 1'b1;
                        w_timerNext = PERIOD_W'(STEP_HIGH - 1);
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dir       <= 1'b1;
            r_microstep <= 4'd4;
            r_remaining <= '0;
            r_period    <= '0;
            r_timer     <= '0;
            r_position  <= '0;
            r_abortPend <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_cmdError  <= 1'b0;
`ifdef STEPPER_SCHED_MORPH_EN
            r_fill      <= 1'b0;
            r_fillCnt   <= '0;
            r_targetMs  <= 4'd4;
`endif
        end else begin
            r_timer    <= w_timerNext;
            r_done     <= w_finishDone;
            r_aborted  <= w_finishAbort;
            r_cmdError <= w_error;

            if (w_nextState == S_IDLE)
                r_abortPend <= 1'b0;
            else if (i_abort && (r_state == S_STEP_HI || r_state == S_STEP_LO))
                r_abortPend <= 1'b1;

            if (w_loadCmd) begin
                r_period <= w_period;
                r_dir    <= w_newDir;
            end

            if (w_enterHi && !w_fillStep)
                r_remaining <= (w_loadCmd ? w_absSteps : r_remaining) - 1'b1;
            else if (w_loadCmd)
                r_remaining <= w_absSteps;

            if (w_enterHi)
                r_position <= r_position + w_delta;

`ifdef STEPPER_SCHED_MORPH_EN
            // During fill the old (finer) microstep stays on the pins until the boundary is met.
            if (w_loadCmd) begin
                r_targetMs <= cmd.cmd_microstep;
                r_fill     <= w_needFill;
                if (!w_needFill) r_microstep <= cmd.cmd_microstep;
            end
            if (w_leaveFill) begin
                r_fill      <= 1'b0;
                r_microstep <= r_targetMs;
            end else if (w_nextState == S_IDLE) begin
                r_fill <= 1'b0;
            end
            if (w_enterHi && w_fillStep)
                r_fillCnt <= (w_loadCmd ? 2'd0 : r_fillCnt) + 2'd1;
            else if (w_loadCmd)
                r_fillCnt <= 2'd0;
`else
            if (w_loadCmd) r_microstep <= cmd.cmd_microstep;
`endif
        end
    end

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_step        = (r_state == S_STEP_HI);
    assign o_dir         = r_dir;
    assign o_microstep   = r_microstep;
    assign o_done        = r_done;
    assign o_aborted     = r_aborted;
    assign o_cmd_error   = r_cmdError;
    assign o_position    = r_position;

endmodule
